// File: rtl/uart_rx_parity.sv
// uart_rx_parity: UART receiver for the platform rx pin.
// Frame: 1 start bit, 8 data bits LSB first, optional even-parity bit, 1 stop bit.
// Build option: define UART_RX_PARITY_EN to include the parity bit (11-bit frame).
// Without it the frame is 8N1 and parity_err is tied low.
//
// Parameters:
//   CLK_FREQ   clock frequency in Hz
//   BAUD_RATE  line rate; CLK_FREQ/BAUD_RATE clocks per bit (must be >= 4)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial input, asynchronous, idles high
//   rx_clr     one-cycle pulse, clears rx_ready and overrun
//   rx_data    last received byte, held until the next frame completes
//   rx_valid   one-cycle pulse when rx_data updates
//   rx_ready   sticky byte-available flag
//   parity_err parity mismatch on the last frame
//   frame_err  stop bit sampled low on the last frame
//   overrun    sticky, a frame completed while rx_ready was set
module uart_rx_parity #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic            done_q;     // stop bit sampled; publish results next cycle
  logic            ferr_nx_q;
  logic            rx_meta;
  logic            rx_s;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_nx_q;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      done_q       <= 1'b0;
      ferr_nx_q    <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_ready     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_nx_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;

      // Completion has priority over a coincident clear.
      if (done_q) begin
        done_q    <= 1'b0;
        rx_data   <= shreg_q;
        rx_valid  <= 1'b1;
        rx_ready  <= 1'b1;
        frame_err <= ferr_nx_q;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= perr_nx_q;
`endif
        if (rx_ready && !rx_clr) begin
          overrun <= 1'b1;
        end
      end else if (rx_clr) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          // Level-sensitive: a held-low line restarts a frame immediately.
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              state_q <= StIdle;  // glitch shorter than half a bit
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q          <= '0;
            shreg_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            perr_nx_q <= ^shreg_q ^ rx_s;  // even parity: odd total is an error
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            ferr_nx_q <= ~rx_s;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

UART receiver that deserialises the `rx` pin of the RISC-V platform into bytes for the processor's memory-mapped UART peripheral. Frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit (compile-time optional), 1 stop bit. Sits directly behind the top-level `rx` input. Presents a held byte, a ready flag with clear handshake, and per-frame error flags to the peripheral register file.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in baud. `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer divide, must be ≥ 4).
- `clk`  input  1  system clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, asynchronous to `clk`, idles high.
- `rx_clr`  input  1  one-cycle pulse from the register file; clears `rx_ready` and `overrun`.
- `rx_data`  output  8  last received byte, held until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `rx_ready`  output  1  sticky "byte available" flag.
- `parity_err`  output  1  parity mismatch on the last frame (updated with `rx_valid`).
- `frame_err`  output  1  stop bit sampled low on the last frame (updated with `rx_valid`).
- `overrun`  output  1  sticky; a frame completed while `rx_ready` was already set.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on `rx_s` = 0 → START, baud counter cleared.
- START: at count `CLKS_PER_BIT/2 - 1` sample `rx_s`; 0 → DATA (counter cleared, bit index 0); 1 → IDLE (glitch rejected, no outputs change).
- DATA: every `CLKS_PER_BIT` clocks sample `rx_s` into shift register bit `[index]`; after index 7 → PARITY (or STOP when parity compiled out).
- PARITY: sample after `CLKS_PER_BIT` clocks; `parity_err_next = ^data ^ sampled_bit` (even parity: error when total ones odd).
- STOP: sample after `CLKS_PER_BIT` clocks; `frame_err_next = ~rx_s`. Next cycle: load `rx_data`, `parity_err`, `frame_err`; pulse `rx_valid`; set `rx_ready`; go to IDLE.
- Byte is delivered even with parity or frame error.
- Overrun: completion with `rx_ready` already 1 sets `overrun`; `rx_data` is overwritten with the new byte.
- Simultaneous `rx_clr` and completion: completion wins; `rx_ready` stays 1, `overrun` not set.
- `rx_clr` in any other cycle clears `rx_ready` and `overrun` next edge; has no effect on FSM.
- After STOP with `frame_err`, IDLE re-arms only on a fresh low level; a held-low line (break) produces repeated frames with `frame_err` = 1.

## Timing
- Reset values: `rx_data` 0x00, `rx_valid` 0, `rx_ready` 0, `parity_err` 0, `frame_err` 0, `overrun` 0, FSM IDLE, counters 0.
- Reset asserted mid-frame aborts immediately; partial byte is discarded.
- Start-edge latency: 2 clocks (synchroniser) + 1 clock into START.
- Sample points: mid-bit, i.e. `CLKS_PER_BIT/2` after the detected edge, then every `CLKS_PER_BIT`.
- `rx_valid` rises 1 clock after the stop-bit sample, i.e. ≈ 10.5 bit times (9.5 without parity) after the start edge.
- Receiver is ready for the next start bit from the cycle `rx_valid` is high; back-to-back frames with no idle gap are received.
- Baud counter width: `$clog2(CLKS_PER_BIT)` bits, wraps to 0 on each sample.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, 11-bit frame, `parity_err` computed as above.
- Undefined: PARITY state removed, 10-bit frame (8N1), `parity_err` tied to 0, `rx_valid` occurs one bit time earlier.

## Test plan
- Parity on, `CLKS_PER_BIT` = 16: send 0x0C with parity 0, stop 1 → `rx_valid` pulse, `rx_data` = 0x0C, `rx_ready` = 1, both error flags 0.
- Send 0x0E with parity 0 → `rx_data` = 0x0E, `parity_err` = 1; then 0x0E with parity 1 → `parity_err` = 0.
- Send 0x03 with stop bit 0 → `rx_data` = 0x03, `frame_err` = 1; next clean frame clears `frame_err`.
- Send 0x0C then 0x03 without pulsing `rx_clr` → `overrun` = 1, `rx_data` = 0x03; `rx_clr` pulse → `rx_ready` = 0, `overrun` = 0.
- 4-clock low glitch on idle `rx` → no `rx_valid`, FSM back in IDLE; assert `rst` during DATA of a frame → all outputs return to reset values, next full frame received correctly.
- `UART_RX_PARITY_EN` undefined: send 0xA5 as 8N1 → `rx_data` = 0xA5, `parity_err` = 0, `rx_valid` 9.5 bit times after start edge (±3 clocks).
